// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO for the UART TX/RX data paths with occupancy status and sticky error flags.
// Define UART_FIFO_REG_RD_EN for registered read data; the default build is show-ahead.
module uart_sync_fifo #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8,
  parameter int AF_LEVEL   = 2**ADDR_WIDTH - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  rd,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_CNT    = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_CNT    = (ADDR_WIDTH+1)'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] w_ptr_p0;
  logic [ADDR_WIDTH-1:0] r_ptr_p0;
  logic [ADDR_WIDTH:0]   cnt_p0;
  logic                  ovf_p0;
  logic                  udf_p0;
  logic                  clr;
  logic                  rd_ok;
  logic                  wr_ok;

  // Occupancy update; a simultaneous push and pop leave the count unchanged.
  function automatic logic [ADDR_WIDTH:0] next_count(
    input logic [ADDR_WIDTH:0] cur,
    input logic                inc,
    input logic                dec
  );
    logic [ADDR_WIDTH:0] res;
    res = cur;
    if (inc && !dec)
      res = cur + 1'b1;
    else if (dec && !inc)
      res = cur - 1'b1;
    return res;
  endfunction

  // Flush and reset suppress acceptance so nothing moves in a clearing cycle.
  always_comb begin
    clr   = reset || flush;
    rd_ok = rd && !clr && !empty;
    wr_ok = wr && !clr && (!full || rd_ok);
  end

  always_comb begin
    full         = (cnt_p0 == DEPTH_CNT);
    empty        = (cnt_p0 == '0);
    almost_full  = (cnt_p0 >= AF_CNT);
    almost_empty = (cnt_p0 <= AE_CNT);
    count        = cnt_p0;
    overflow     = ovf_p0;
    underflow    = udf_p0;
  end

  // Stage p0: pointers, occupancy and sticky flags
  always_ff @(posedge clk) begin
    if (clr) begin
      w_ptr_p0 <= '0;
      r_ptr_p0 <= '0;
      cnt_p0   <= '0;
      ovf_p0   <= 1'b0;
      udf_p0   <= 1'b0;
    end else begin
      if (wr_ok)
        w_ptr_p0 <= w_ptr_p0 + 1'b1;
      if (rd_ok)
        r_ptr_p0 <= r_ptr_p0 + 1'b1;
      cnt_p0 <= next_count(cnt_p0, wr_ok, rd_ok);
      if (wr && !wr_ok)
        ovf_p0 <= 1'b1;
      if (rd && !rd_ok)
        udf_p0 <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[w_ptr_p0] <= w_data;
  end

`ifdef UART_FIFO_REG_RD_EN
  logic [DATA_WIDTH-1:0] r_data_p1;

  // Stage p1: popped word captured on the accepting edge
  always_ff @(posedge clk) begin
    if (clr)
      r_data_p1 <= '0;
    else if (rd_ok)
      r_data_p1 <= mem[r_ptr_p0];
  end

  assign r_data = r_data_p1;
`else
  assign r_data = mem[r_ptr_p0];
`endif

endmodule

// File: tb/tb_uart_sync_fifo.sv
// Self-checking bench for uart_sync_fifo against a queue-based reference model.
// Works with or without UART_FIFO_REG_RD_EN defined.
module tb_uart_sync_fifo;

  localparam int AW    = 3;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AF    = 7;
  localparam int AE    = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr;
  logic [DW-1:0] w_data;
  logic          rd;
  logic          flush;
  logic [DW-1:0] r_data;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  int vectors = 0;
  int errors  = 0;

  logic [DW-1:0] q[$];
  logic          m_ovf;
  logic          m_udf;
  logic [DW-1:0] m_rdata;

  uart_sync_fifo #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .AF_LEVEL   (AF),
    .AE_LEVEL   (AE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr           (wr),
    .w_data       (w_data),
    .rd           (rd),
    .flush        (flush),
    .r_data       (r_data),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  // One clock cycle: drive, advance the model, compare. got returns the word read.
  task automatic do_cycle(input bit r, input bit f, input bit w, input logic [DW-1:0] d,
                          input bit rr, output logic [DW-1:0] got);
    bit clr, rok, wok;
    logic [4:0] exp_flags, act_flags;
    reset = r; flush = f; wr = w; w_data = d; rd = rr;
    got = 'x;
    @(negedge clk);
`ifndef UART_FIFO_REG_RD_EN
    if (q.size() > 0) begin
      vectors++;
      if (r_data !== q[0]) begin
        errors++;
        $display("FAIL showahead_data: got %h required %h", r_data, q[0]);
      end
      got = r_data;
    end
`endif
    @(posedge clk);
    clr = r || f;
    rok = rr && !clr && (q.size() > 0);
    wok = w && !clr && ((q.size() < DEPTH) || rok);
    if (clr) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      m_rdata = '0;
    end else begin
      if (w && !wok) m_ovf = 1'b1;
      if (rr && !rok) m_udf = 1'b1;
      if (rok) m_rdata = q.pop_front();
      if (wok) q.push_back(d);
    end
    #1;
    vectors++;
    if (int'(count) !== q.size()) begin
      errors++;
      $display("FAIL count: got %0d required %0d", count, q.size());
    end
    exp_flags = {q.size() == DEPTH, q.size() == 0, q.size() >= AF, q.size() <= AE, 1'b0};
    act_flags = {full, empty, almost_full, almost_empty, 1'b0};
    vectors++;
    if (act_flags !== exp_flags || overflow !== m_ovf || underflow !== m_udf) begin
      errors++;
      $display("FAIL status: got f/e/af/ae=%b ovf=%b udf=%b required %b ovf=%b udf=%b",
               act_flags[4:1], overflow, underflow, exp_flags[4:1], m_ovf, m_udf);
    end
`ifdef UART_FIFO_REG_RD_EN
    vectors++;
    if (r_data !== m_rdata) begin
      errors++;
      $display("FAIL reg_data: got %h required %h", r_data, m_rdata);
    end
    if (rok) got = r_data;
`endif
  endtask

  task automatic test_reset();
    logic [DW-1:0] g;
    do_cycle(1, 0, 1, 8'h77, 1, g);
    vectors++;
    if ({count, empty, full, almost_empty, almost_full, overflow, underflow} !== {4'd0, 6'b101000}) begin
      errors++;
      $display("FAIL reset_state: got cnt=%0d e=%b f=%b ae=%b af=%b ovf=%b udf=%b required 0 1 0 1 0 0 0",
               count, empty, full, almost_empty, almost_full, overflow, underflow);
    end
  endtask

  task automatic test_fill_overflow();
    logic [DW-1:0] g;
    for (int i = 0; i < DEPTH; i++) begin
      do_cycle(0, 0, 1, 8'h11 + DW'(i), 0, g);
      vectors++;
      if (almost_full !== (i + 1 >= 7)) begin
        errors++;
        $display("FAIL fill_af: got %b required %b at count %0d", almost_full, (i + 1 >= 7), i + 1);
      end
    end
    vectors++;
    if (count !== 4'd8 || full !== 1'b1) begin
      errors++;
      $display("FAIL fill_full: got cnt=%0d full=%b required 8 1", count, full);
    end
    do_cycle(0, 0, 1, 8'h99, 0, g);
    vectors++;
    if (overflow !== 1'b1 || count !== 4'd8) begin
      errors++;
      $display("FAIL overflow: got ovf=%b cnt=%0d required 1 8", overflow, count);
    end
  endtask

  task automatic test_drain_underflow();
    logic [DW-1:0] g;
    for (int i = 0; i < DEPTH; i++) begin
      do_cycle(0, 0, 0, '0, 1, g);
      vectors++;
      if (g !== 8'h11 + DW'(i)) begin
        errors++;
        $display("FAIL drain_data: got %h required %h", g, 8'h11 + DW'(i));
      end
    end
    do_cycle(0, 0, 0, '0, 1, g);
    vectors++;
    if (underflow !== 1'b1 || count !== 4'd0 || empty !== 1'b1 || almost_empty !== 1'b1) begin
      errors++;
      $display("FAIL underflow: got udf=%b cnt=%0d e=%b ae=%b required 1 0 1 1",
               underflow, count, empty, almost_empty);
    end
  endtask

  task automatic test_full_rw();
    logic [DW-1:0] g;
    do_cycle(0, 1, 0, '0, 0, g);
    for (int i = 0; i < DEPTH; i++)
      do_cycle(0, 0, 1, DW'($urandom_range(0, 255)), 0, g);
    do_cycle(0, 0, 1, 8'hA5, 1, g);
    vectors++;
    if (count !== 4'd8 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_rw: got cnt=%0d ovf=%b required 8 0", count, overflow);
    end
    for (int i = 0; i < DEPTH; i++)
      do_cycle(0, 0, 0, '0, 1, g);
    vectors++;
    if (g !== 8'hA5) begin
      errors++;
      $display("FAIL full_rw_data: got %h required a5", g);
    end
  endtask

  task automatic test_empty_rw();
    logic [DW-1:0] g;
    do_cycle(0, 1, 0, '0, 0, g);
    do_cycle(0, 0, 1, 8'h3C, 1, g);
    vectors++;
    if (count !== 4'd1 || underflow !== 1'b1) begin
      errors++;
      $display("FAIL empty_rw: got cnt=%0d udf=%b required 1 1", count, underflow);
    end
    do_cycle(0, 0, 0, '0, 1, g);
    vectors++;
    if (g !== 8'h3C) begin
      errors++;
      $display("FAIL empty_rw_data: got %h required 3c", g);
    end
  endtask

  task automatic test_flush_wrap();
    logic [DW-1:0] g, x;
    for (int i = 0; i < 5; i++)
      do_cycle(0, 0, 1, DW'($urandom_range(0, 255)), 0, g);
    do_cycle(0, 1, 1, 8'hEE, 1, g);
    vectors++;
    if (count !== 4'd0 || empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++;
      $display("FAIL flush: got cnt=%0d e=%b ovf=%b udf=%b required 0 1 0 0",
               count, empty, overflow, underflow);
    end
    for (int i = 0; i < 20; i++) begin
      x = DW'($urandom_range(0, 255));
      do_cycle(0, 0, 1, x, 0, g);
      do_cycle(0, 0, 0, '0, 1, g);
      vectors++;
      if (g !== x) begin
        errors++;
        $display("FAIL wrap_data: pair %0d got %h required %h", i, g, x);
      end
    end
  endtask

  task automatic test_read_timing();
    logic [DW-1:0] g;
    do_cycle(0, 1, 0, '0, 0, g);
    do_cycle(0, 0, 1, 8'h5A, 0, g);
    reset = 0; flush = 0; wr = 0; rd = 1;
    @(negedge clk);
`ifndef UART_FIFO_REG_RD_EN
    vectors++;
    if (r_data !== 8'h5A) begin
      errors++;
      $display("FAIL showahead_timing: got %h required 5a before rd edge", r_data);
    end
`endif
    @(posedge clk);
    void'(q.pop_front());
    m_rdata = 8'h5A;
    #1;
`ifdef UART_FIFO_REG_RD_EN
    vectors++;
    if (r_data !== 8'h5A) begin
      errors++;
      $display("FAIL reg_timing: got %h required 5a after rd edge", r_data);
    end
`endif
    do_cycle(0, 0, 0, '0, 0, g);
  endtask

  task automatic test_random();
    logic [DW-1:0] g;
    for (int i = 0; i < 400; i++) begin
      do_cycle($urandom_range(0, 99) == 0, $urandom_range(0, 49) == 0,
               $urandom_range(0, 99) < 55, DW'($urandom), $urandom_range(0, 99) < 50, g);
    end
  endtask

  initial begin
    reset = 1; flush = 0; wr = 0; rd = 0; w_data = '0;
    m_ovf = 0; m_udf = 0; m_rdata = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_fill_overflow();
    test_drain_underflow();
    test_full_rw();
    test_empty_rw();
    test_flush_wrap();
    test_read_timing();
    test_random();
    test_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
